// File: rtl/memshare_rqst_profiler.sv
// memshare_rqst_profiler
//   Arrival-requestor profiler in front of the memShare L1PA control regFile.
//   Incoming share-group request patterns are queued in a small FIFO. The FSM
//   takes the head entry and runs the three memShare DRCs on it:
//     DRC1 : each active requestor's address is in its group's bank set
//     DRC2 : no address is shared by more than MAX_ALLOC_SEQ_NUM requestors
//     DRC3 : the pattern has at least one active requestor
//   A legal pattern is sent out as one or two regFile page lookups (isGtr
//   pointer on alloc_seqptr). An illegal pattern is dropped, drc_viol pulses,
//   and the failing DRC bits are ORed into the sticky drc_err.
//   Optional build macro MEMSHARE_PROFILE_STATS_EN adds the saturating
//   stat_arr_cnt / stat_viol_cnt counters and their output ports.
module memshare_rqst_profiler #(
  parameter int                          SHARE_GROUP_SIZE   = 5,
  parameter int                          RQST_ADDR_BITWIDTH = 2,
  parameter int                          TRACK_DEPTH        = 4,
  parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG   = 5'b10101,
  parameter int                          PAGE_ADDR_WIDTH    = 5
) (
  input  logic                                         sys_clk,
  input  logic                                         rstn,
  input  logic                                         rqst_valid,
  output logic                                         rqst_ready,
  input  logic [SHARE_GROUP_SIZE-1:0]                  rqst_flag,
  input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_addr,
  output logic                                         alloc_valid,
  input  logic                                         alloc_ready,
  output logic [PAGE_ADDR_WIDTH-1:0]                   alloc_page,
  output logic                                         alloc_seqptr,
  output logic                                         drc_viol,
  output logic [2:0]                                   drc_err,
  input  logic                                         drc_err_clr
`ifdef MEMSHARE_PROFILE_STATS_EN
  ,
  output logic [15:0]                                  stat_arr_cnt,
  output logic [15:0]                                  stat_viol_cnt
`endif
);

  localparam int ADDR_W            = SHARE_GROUP_SIZE * RQST_ADDR_BITWIDTH;
  localparam int PTR_W             = (TRACK_DEPTH > 1) ? $clog2(TRACK_DEPTH) : 1;
  localparam int CNT_W             = $clog2(TRACK_DEPTH + 1);
  localparam int SEQ_CNT_W         = $clog2(SHARE_GROUP_SIZE + 1);
  localparam int NUM_ADDR          = 1 << RQST_ADDR_BITWIDTH;
  localparam int MAX_ALLOC_SEQ_NUM = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE
  } state_t;

  // Pattern FIFO storage and pointers
  logic [SHARE_GROUP_SIZE-1:0] r_mem_flag [TRACK_DEPTH];
  logic [ADDR_W-1:0]           r_mem_addr [TRACK_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_count;

  // FSM state and registered outputs
  state_t                      r_state;
  logic                        r_need2;
  logic                        r_alloc_valid;
  logic [PAGE_ADDR_WIDTH-1:0]  r_alloc_page;
  logic                        r_alloc_seqptr;
  logic                        r_drc_viol;
  logic [2:0]                  r_drc_err;

  // Combinational datapath
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  logic [SHARE_GROUP_SIZE-1:0] w_head_flag;
  logic [ADDR_W-1:0]           w_head_addr;
  logic [RQST_ADDR_BITWIDTH-1:0] w_a;
  logic [SEQ_CNT_W-1:0]        w_seq_cnt;
  logic                        w_drc1;
  logic                        w_drc2;
  logic                        w_drc3;
  logic                        w_need2;
  logic                        w_fail;

  assign w_full      = (r_count == CNT_W'(TRACK_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = rqst_valid && !w_full;
  assign w_head_flag = r_mem_flag[r_rd_ptr];
  assign w_head_addr = r_mem_addr[r_rd_ptr];
  assign w_fail      = w_drc1 || w_drc2 || w_drc3;

  assign rqst_ready   = !w_full;
  assign alloc_valid  = r_alloc_valid;
  assign alloc_page   = r_alloc_page;
  assign alloc_seqptr = r_alloc_seqptr;
  assign drc_viol     = r_drc_viol;
  assign drc_err      = r_drc_err;

  // DRC evaluation of the FIFO head pattern
  always_comb begin
    w_drc1    = 1'b0;
    w_drc2    = 1'b0;
    w_drc3    = (w_head_flag == '0);
    w_need2   = 1'b0;
    w_a       = '0;
    w_seq_cnt = '0;
    // Bank parity: shared (GP2) columns use odd banks, GP1 columns even banks
    for (int unsigned i = 0; i < SHARE_GROUP_SIZE; i++) begin
      w_a = w_head_addr[i*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH];
      if (w_head_flag[i]) begin
        if (32'(w_a) > 32'd3) begin
          w_drc1 = 1'b1;
        end else if (w_a[0] != SHARE_COL_CONFIG[i]) begin
          w_drc1 = 1'b1;
        end
      end
    end
    // Worst-case sharing count over every possible bank address
    for (int unsigned v = 0; v < NUM_ADDR; v++) begin
      w_seq_cnt = '0;
      for (int unsigned i = 0; i < SHARE_GROUP_SIZE; i++) begin
        w_a = w_head_addr[i*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH];
        if (w_head_flag[i] && (w_a == RQST_ADDR_BITWIDTH'(v))) begin
          w_seq_cnt = w_seq_cnt + SEQ_CNT_W'(1);
        end
      end
      if (w_seq_cnt > SEQ_CNT_W'(MAX_ALLOC_SEQ_NUM)) begin
        w_drc2 = 1'b1;
      end else if (w_seq_cnt == SEQ_CNT_W'(MAX_ALLOC_SEQ_NUM)) begin
        w_need2 = 1'b1;
      end
    end
  end

  // Head pop: dropped in CHECK, or accepted final allocation sequence in ISSUE
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_CHECK: w_pop = w_fail;
      S_ISSUE: w_pop = alloc_ready && !(r_need2 && !r_alloc_seqptr);
      default: w_pop = 1'b0;
    endcase
  end

  // FIFO pattern storage (no reset needed; validity comes from the pointers)
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem_flag[r_wr_ptr] <= rqst_flag;
      r_mem_addr[r_wr_ptr] <= rqst_addr;
    end
  end

  // FIFO pointers and occupancy; a pop never frees space for a same-cycle push
  always_ff @(posedge sys_clk or posedge rstn) begin
    if (rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(TRACK_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(TRACK_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Profiler FSM with registered lookup and DRC outputs
  always_ff @(posedge sys_clk or posedge rstn) begin
    if (rstn) begin
      r_state        <= S_IDLE;
      r_need2        <= 1'b0;
      r_alloc_valid  <= 1'b0;
      r_alloc_page   <= '0;
      r_alloc_seqptr <= 1'b0;
      r_drc_viol     <= 1'b0;
      r_drc_err      <= '0;
    end else begin
      r_drc_viol <= 1'b0;
      if (drc_err_clr) begin
        r_drc_err <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_need2 <= w_need2;
          if (w_fail) begin
            // A new violation lands on top of a same-cycle clear
            r_drc_viol <= 1'b1;
            r_drc_err  <= (drc_err_clr ? 3'b000 : r_drc_err) | {w_drc3, w_drc2, w_drc1};
            r_state    <= S_IDLE;
          end else begin
            r_alloc_valid  <= 1'b1;
            r_alloc_page   <= PAGE_ADDR_WIDTH'(w_head_flag);
            r_alloc_seqptr <= 1'b0;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (alloc_ready) begin
            if (r_need2 && !r_alloc_seqptr) begin
              r_alloc_seqptr <= 1'b1;
            end else begin
              r_alloc_valid <= 1'b0;
              r_state       <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEMSHARE_PROFILE_STATS_EN
  logic [15:0] r_stat_arr;
  logic [15:0] r_stat_viol;

  assign stat_arr_cnt  = r_stat_arr;
  assign stat_viol_cnt = r_stat_viol;

  // Saturating arrival / violation counters; an event on a clear cycle counts
  always_ff @(posedge sys_clk or posedge rstn) begin
    if (rstn) begin
      r_stat_arr  <= '0;
      r_stat_viol <= '0;
    end else begin
      if (drc_err_clr) begin
        r_stat_arr <= {15'd0, w_push};
      end else if (w_push && (r_stat_arr != '1)) begin
        r_stat_arr <= r_stat_arr + 16'd1;
      end
      if (drc_err_clr) begin
        r_stat_viol <= {15'd0, r_drc_viol};
      end else if (r_drc_viol && (r_stat_viol != '1)) begin
        r_stat_viol <= r_stat_viol + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memshare_rqst_profiler.sv
// Self-checking bench for memshare_rqst_profiler (default build).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_memshare_rqst_profiler;

  typedef struct packed {
    logic [4:0] page;
    logic       seq;
  } beat_t;

  logic       sys_clk = 1'b0;
  logic       rstn = 1'b1;
  logic       rqst_valid = 1'b0;
  logic       rqst_ready;
  logic [4:0] rqst_flag = '0;
  logic [9:0] rqst_addr = '0;
  logic       alloc_valid;
  logic       alloc_ready = 1'b0;
  logic [4:0] alloc_page;
  logic       alloc_seqptr;
  logic       drc_viol;
  logic [2:0] drc_err;
  logic       drc_err_clr = 1'b0;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  beat_t exp_b;
  logic [4:0] pf [5];
  logic [9:0] pa [5];

  memshare_rqst_profiler #(
    .SHARE_GROUP_SIZE  (5),
    .RQST_ADDR_BITWIDTH(2),
    .TRACK_DEPTH       (4),
    .SHARE_COL_CONFIG  (5'b10101),
    .PAGE_ADDR_WIDTH   (5)
  ) dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .rqst_valid  (rqst_valid),
    .rqst_ready  (rqst_ready),
    .rqst_flag   (rqst_flag),
    .rqst_addr   (rqst_addr),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_page  (alloc_page),
    .alloc_seqptr(alloc_seqptr),
    .drc_viol    (drc_viol),
    .drc_err     (drc_err),
    .drc_err_clr (drc_err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One-cycle push; caller guarantees rqst_ready is high
  task automatic drive(input logic [4:0] f, input logic [9:0] a);
    rqst_valid = 1'b1;
    rqst_flag  = f;
    rqst_addr  = a;
    tick();
    rqst_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (rqst_ready !== 1'b1)   begin errors++; $display("FAIL reset_rqst_ready got %b exp 1", rqst_ready); end
    checks++; if (alloc_valid !== 1'b0)  begin errors++; $display("FAIL reset_alloc_valid got %b exp 0", alloc_valid); end
    checks++; if (alloc_page !== 5'b0)   begin errors++; $display("FAIL reset_alloc_page got %b exp 00000", alloc_page); end
    checks++; if (alloc_seqptr !== 1'b0) begin errors++; $display("FAIL reset_alloc_seqptr got %b exp 0", alloc_seqptr); end
    checks++; if (drc_viol !== 1'b0)     begin errors++; $display("FAIL reset_drc_viol got %b exp 0", drc_viol); end
    checks++; if (drc_err !== 3'b000)    begin errors++; $display("FAIL reset_drc_err got %b exp 000", drc_err); end
    rstn = 1'b0;
    tick();
  endtask

  // flag=00011, r0=1, r1=0: one beat on the 3rd cycle after the accepting edge
  task automatic test_single();
    int lat;
    alloc_ready = 1'b1;
    sb.push_back({5'b00011, 1'b0});
    drive(5'b00011, 10'h001);
    lat = 0;
    while (!alloc_valid && lat < 10) begin
      tick();
      lat++;
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency got %0d exp 2 cycles after accept cycle", lat); end
    exp_b = sb.pop_front();
    checks++;
    if ({alloc_valid, alloc_page, alloc_seqptr} !== {1'b1, exp_b.page, exp_b.seq}) begin
      errors++;
      $display("FAIL single_beat got v=%b page=%b seq=%b exp v=1 page=%b seq=%b",
               alloc_valid, alloc_page, alloc_seqptr, exp_b.page, exp_b.seq);
    end
    tick();
    checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL single_done got valid=%b exp 0", alloc_valid); end
    checks++; if (drc_err !== 3'b000)   begin errors++; $display("FAIL single_drc_err got %b exp 000", drc_err); end
  endtask

  // flag=00101, r0=r2=1: two sequences on the same page
  task automatic test_two_seq();
    int busy;
    sb.push_back({5'b00101, 1'b0});
    sb.push_back({5'b00101, 1'b1});
    drive(5'b00101, 10'h011);
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      if (alloc_valid && alloc_ready) begin
        exp_b = sb.pop_front();
        checks++;
        if ({alloc_page, alloc_seqptr} !== exp_b) begin
          errors++;
          $display("FAIL two_seq_beat got page=%b seq=%b exp page=%b seq=%b",
                   alloc_page, alloc_seqptr, exp_b.page, exp_b.seq);
        end
      end
      tick();
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL two_seq_drain got %0d pending exp 0", sb.size()); end
    sb.delete();
    busy = 0;
    repeat (5) begin
      if (alloc_valid) busy++;
      tick();
    end
    checks++; if (busy !== 0) begin errors++; $display("FAIL two_seq_empty got %0d extra valid cycles exp 0", busy); end
  endtask

  // flag=10101, r0=r2=r4=3: three on one bank -> DRC2 drop
  task automatic test_violation();
    int nviol, nvalid;
    drive(5'b10101, 10'h333);
    nviol = 0;
    nvalid = 0;
    repeat (8) begin
      if (drc_viol) nviol++;
      if (alloc_valid) nvalid++;
      tick();
    end
    checks++; if (nviol !== 1)        begin errors++; $display("FAIL viol_pulse got %0d cycles exp 1", nviol); end
    checks++; if (nvalid !== 0)       begin errors++; $display("FAIL viol_no_alloc got %0d cycles exp 0", nvalid); end
    checks++; if (drc_err !== 3'b010) begin errors++; $display("FAIL viol_drc_err got %b exp 010", drc_err); end
    drc_err_clr = 1'b1;
    tick();
    drc_err_clr = 1'b0;
    checks++; if (drc_err !== 3'b000) begin errors++; $display("FAIL viol_clear got %b exp 000", drc_err); end
  endtask

  // DRC1 then DRC3 accumulate; a violation on a clear cycle survives the clear
  task automatic test_drc_err();
    drive(5'b00010, 10'h004);
    repeat (6) tick();
    checks++; if (drc_err !== 3'b001) begin errors++; $display("FAIL drc1 got %b exp 001", drc_err); end
    drive(5'b00000, 10'h000);
    repeat (6) tick();
    checks++; if (drc_err !== 3'b101) begin errors++; $display("FAIL drc3 got %b exp 101", drc_err); end
    drive(5'b00010, 10'h004);
    tick();
    drc_err_clr = 1'b1;
    tick();
    drc_err_clr = 1'b0;
    checks++; if (drc_err !== 3'b001) begin errors++; $display("FAIL clr_vs_set got %b exp 001", drc_err); end
    checks++; if (drc_viol !== 1'b1)  begin errors++; $display("FAIL clr_vs_set_viol got %b exp 1", drc_viol); end
    repeat (4) tick();
    drc_err_clr = 1'b1;
    tick();
    drc_err_clr = 1'b0;
    checks++; if (drc_err !== 3'b000) begin errors++; $display("FAIL drc_clear got %b exp 000", drc_err); end
  endtask

  // Fill the FIFO with the lookup port stalled; 5th push waits for the first pop
  task automatic test_back_to_back();
    int held, acc, accepted5;
    alloc_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sb.push_back({pf[k], 1'b0});
      drive(pf[k], pa[k]);
    end
    checks++; if (rqst_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got ready=%b exp 0", rqst_ready); end
    rqst_valid = 1'b1;
    rqst_flag  = pf[4];
    rqst_addr  = pa[4];
    held = 0;
    repeat (3) begin
      tick();
      if (rqst_ready) held++;
    end
    checks++; if (held !== 0) begin errors++; $display("FAIL b2b_held got %0d ready cycles exp 0", held); end
    checks++;
    if ({alloc_valid, alloc_page} !== {1'b1, pf[0]}) begin
      errors++;
      $display("FAIL b2b_stall got v=%b page=%b exp v=1 page=%b", alloc_valid, alloc_page, pf[0]);
    end
    alloc_ready = 1'b1;
    accepted5 = 0;
    for (int c = 0; c < 60 && (sb.size() != 0 || accepted5 == 0); c++) begin
      acc = (rqst_valid && rqst_ready) ? 1 : 0;
      if (alloc_valid && alloc_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected got page=%b seq=%b exp no beat", alloc_page, alloc_seqptr);
        end else begin
          exp_b = sb.pop_front();
          if ({alloc_page, alloc_seqptr} !== exp_b) begin
            errors++;
            $display("FAIL b2b_order got page=%b seq=%b exp page=%b seq=%b",
                     alloc_page, alloc_seqptr, exp_b.page, exp_b.seq);
          end
        end
      end
      tick();
      if (acc != 0 && accepted5 == 0) begin
        rqst_valid = 1'b0;
        accepted5 = 1;
        sb.push_back({pf[4], 1'b0});
      end
    end
    checks++;
    if (sb.size() != 0 || accepted5 == 0) begin
      errors++;
      $display("FAIL b2b_drain got pending=%0d accepted5=%0d exp 0 and 1", sb.size(), accepted5);
    end
    rqst_valid = 1'b0;
    sb.delete();
  endtask

  // Async reset while a lookup is stalled with three entries queued
  task automatic test_reset_mid();
    int w, busy;
    alloc_ready = 1'b0;
    for (int k = 0; k < 3; k++) drive(pf[k], pa[k]);
    w = 0;
    while (!alloc_valid && w < 10) begin
      tick();
      w++;
    end
    checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL rmid_issue got valid=%b exp 1", alloc_valid); end
    rstn = 1'b1;
    tick();
    checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", alloc_valid); end
    checks++; if (rqst_ready !== 1'b1)  begin errors++; $display("FAIL rmid_ready got %b exp 1", rqst_ready); end
    checks++; if (alloc_page !== 5'b0)  begin errors++; $display("FAIL rmid_page got %b exp 00000", alloc_page); end
    rstn = 1'b0;
    tick();
    alloc_ready = 1'b1;
    sb.push_back({pf[3], 1'b0});
    drive(pf[3], pa[3]);
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      if (alloc_valid && alloc_ready) begin
        exp_b = sb.pop_front();
        checks++;
        if ({alloc_page, alloc_seqptr} !== exp_b) begin
          errors++;
          $display("FAIL rmid_beat got page=%b seq=%b exp page=%b seq=%b",
                   alloc_page, alloc_seqptr, exp_b.page, exp_b.seq);
        end
      end
      tick();
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rmid_drain got %0d pending exp 0", sb.size()); end
    busy = 0;
    repeat (6) begin
      if (alloc_valid) busy++;
      tick();
    end
    checks++; if (busy !== 0) begin errors++; $display("FAIL rmid_stale got %0d valid cycles exp 0", busy); end
  endtask

  initial begin
    // Legal single-sequence patterns: {flag, addr}
    pf[0] = 5'b00001; pa[0] = 10'h001;
    pf[1] = 5'b00010; pa[1] = 10'h000;
    pf[2] = 5'b00011; pa[2] = 10'h00B;
    pf[3] = 5'b10000; pa[3] = 10'h100;
    pf[4] = 5'b01000; pa[4] = 10'h080;
    test_reset();
    test_single();
    test_two_seq();
    test_violation();
    test_drc_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
